seq11011_tx: RTL and testbench
==============================

# seq11011_tx

Serial frame transmitter that produces the bit stream consumed by the overlapping 11011 Mealy detector. It accepts a parallel payload through a valid/ready handshake and sends one frame per payload, one bit per clock. Each frame is the sync word 11011, then the payload MSB first with zero-stuffing, then an idle gap. Stuffing guarantees that a downstream overlapping 11011 detector fires exactly once per frame, on the last sync bit.

## Interface
- DATA_W, 8, payload width in bits (≥1)
- GAP, 2, idle zero bits after each frame (≥1)

- clk  input  1  clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- start  input  1  request to send `data`; accepted on a clock edge where `start && ready`
- data  input  DATA_W  payload; sampled only at acceptance
- ready  output  1  high only in IDLE
- out  output  1  registered serial bit line
- out_valid  output  1  registered; high while a sync, payload or stuff bit is on `out`
- stuff  output  1  registered; high while the bit on `out` is a stuffed 0
- done  output  1  registered one-cycle pulse on the last gap bit

## Operation
- States: IDLE, SYNC, DATA, STUFF, GAP.
- IDLE: `out`=0, `out_valid`=0, `ready`=1.
  - On `start`, latch `data` into the shift register, clear `bit_cnt`, and go to SYNC.
  - `start` while not ready is ignored. It is not queued.
- SYNC: drive 1,1,0,1,1 over 5 cycles, then go to DATA.
- DATA: drive shift-register MSB, shift left, and increment `bit_cnt`.
  - After DATA_W payload bits, go to GAP.
  - If a stuff is due (see below), go to STUFF first.
- STUFF: drive 0 with `stuff`=1.
  - Return to DATA if payload bits remain, otherwise go to GAP.
- GAP: drive 0 with `out_valid`=0 for GAP cycles.
  - `done`=1 on the final gap cycle, then go to IDLE.
- Stuff rule:
  - A 4-bit history `hist` holds the last four transmitted bits, including sync bits.
  - It is cleared to 0000 at acceptance.
  - Whenever `hist`==1101 after a bit is sent, the next transmitted bit is a stuffed 0.
  - The stuffed 0 is not a payload bit.
  - The rule also applies after the last payload bit, so a trailing stuff is sent before GAP.
  - The stuffed 0 updates `hist` like any other bit.
  - The receiver destuffs by dropping the bit that follows 1101.
- Width rules:
  - `bit_cnt` is wide enough to count to DATA_W.
  - Gap counter is wide enough to count to GAP.
  - Neither counter wraps inside a frame.
- Stuff count per frame is at most ceil(DATA_W/2). Frame length is 5 + DATA_W + stuffs + GAP cycles.

## Timing
- Reset values:
  - `out`=0, `out_valid`=0, `stuff`=0, `done`=0.
  - `ready`=1 from the cycle after the reset edge.
  - State = IDLE, `hist`=0000, counters = 0.
- Reset mid-frame aborts immediately. `out`=0 from the cycle after the reset edge, and the partial frame is not resumed.
- Latency: if `start` is accepted at edge k, the first sync bit is on `out` during cycle k+1 (after edge k).
- `ready` falls in the same cycle the first sync bit appears. It rises the cycle after `done`.
- Back-to-back frames:
  - `start` held high is accepted on the first cycle `ready`=1.
  - Minimum inter-frame idle is GAP zeros plus one IDLE cycle.
- `rst` and `start` asserted together: reset wins and nothing is accepted.
- `data` changes after acceptance have no effect on the frame in flight.

## Test plan
- 8'hA5 → `out` = 11011 1010 00101, then 00.
  - `stuff` is high only on bit index 8 (0-based).
  - `done` pulses once, and 16 cycles elapse from first sync bit to `ready`.
- 8'hFF → 11011 11111111, then 00. Zero stuffs, and `out_valid` is high for exactly 13 cycles.
- 8'h6D → 11011 0 1 0s 1 0 1 1 0 1 0s, then 00.
  - There are 2 stuffs, one of them trailing after the last payload bit.
  - A reference overlapping 11011 detector on `out` fires exactly once, on the 5th bit.
- Back-to-back: hold `start`=1 with A5 then FF.
  - The second frame starts exactly one IDLE cycle after the first `done`.
  - `start` pulses while `ready`=0 are ignored.
- Reset at the 3rd payload bit of A5 → `out`=0 and `ready`=1 the following cycle.
  - A new 8'hFF frame afterwards matches its golden stream, with `hist` reset and no spurious stuff.
- Random payloads, 1000 frames, DATA_W=8, GAP=1:
  - A destuffing model recovers every payload.
  - A detector model fires exactly once per frame.

Source files
------------

// File: rtl/seq11011_tx.sv
// -----------------------------------------------------------------------------
// seq11011_tx
//
// Serial frame transmitter. Each accepted payload is sent as one frame, one
// bit per clock: the sync word 11011, then the payload MSB first with
// zero-stuffing, then GAP idle zeros. Stuffing keeps the pattern 11011 from
// appearing anywhere except at the end of the sync word. A downstream
// overlapping 11011 detector therefore fires exactly once per frame.
//
// Parameters
//   DATA_W    payload width in bits (>= 1)
//   GAP       idle zero bits after each frame (>= 1)
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   start      request to send data, accepted when start && ready
//   data       payload, sampled only at acceptance
//   ready      high only while idle
//   out        registered serial bit line
//   out_valid  high while a sync, payload or stuff bit is on out
//   stuff      high while the bit on out is a stuffed 0
//   done       one-cycle pulse on the last gap bit
// -----------------------------------------------------------------------------
module seq11011_tx #(
  parameter int DATA_W = 8,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              out,
  output logic              out_valid,
  output logic              stuff,
  output logic              done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int GW = $clog2(GAP + 1);

  // The state names the kind of bit currently on out.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_STUFF,
    S_GAP
  } state_t;

  state_t            state;
  state_t            nxt;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;   // payload bits sent so far
  logic [GW-1:0]     gap_cnt;   // index (1-based) of the gap bit on out
  logic [3:0]        hist;      // last four bits sent, newest in bit 0
  logic [3:0]        sync_sr;   // sync bits still to send, next in bit 3
  logic [2:0]        sync_cnt;  // number of sync bits still to send

  logic              stuff_due;
  logic              payload_done;
  logic [GW-1:0]     gap_next;

  assign stuff_due    = (hist == 4'b1101);
  assign payload_done = (bit_cnt == BW'(DATA_W));
  assign gap_next     = (state == S_GAP) ? gap_cnt + 1'b1 : GW'(1);

  // Decide what kind of bit goes on out in the next cycle. The sync word
  // itself contains 1101 but is never stuffed, so the stuff rule is only
  // evaluated after payload bits.
  always_comb begin
    // NOTE: default first so every path assigns nxt and no latch is inferred.
    nxt = state;
    case (state)
      S_IDLE:  nxt = start ? S_SYNC : S_IDLE;
      S_SYNC:  nxt = (sync_cnt != 3'd0) ? S_SYNC : S_DATA;
      S_DATA:  nxt = stuff_due ? S_STUFF : (payload_done ? S_GAP : S_DATA);
      S_STUFF: nxt = payload_done ? S_GAP : S_DATA;
      S_GAP:   nxt = (gap_cnt == GW'(GAP)) ? S_IDLE : S_GAP;
      default: nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ready     <= 1'b1;
      out       <= 1'b0;
      out_valid <= 1'b0;
      stuff     <= 1'b0;
      done      <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      hist      <= '0;
      sync_sr   <= '0;
      sync_cnt  <= '0;
    end else begin
      state <= nxt;
      stuff <= 1'b0;
      done  <= 1'b0;
      case (nxt)
        S_IDLE: begin
          ready     <= 1'b1;
          out       <= 1'b0;
          out_valid <= 1'b0;
          gap_cnt   <= '0;
        end
        S_SYNC: begin
          ready     <= 1'b0;
          out_valid <= 1'b1;
          if (state == S_IDLE) begin
            // Acceptance: the first sync bit goes out immediately. hist is
            // cleared and that first 1 is shifted in on the same edge.
            shreg    <= data;
            bit_cnt  <= '0;
            out      <= 1'b1;
            hist     <= 4'b0001;
            sync_sr  <= 4'b1011;
            sync_cnt <= 3'd4;
          end else begin
            out      <= sync_sr[3];
            hist     <= {hist[2:0], sync_sr[3]};
            sync_sr  <= {sync_sr[2:0], 1'b0};
            sync_cnt <= sync_cnt - 1'b1;
          end
        end
        S_DATA: begin
          out       <= shreg[DATA_W-1];
          out_valid <= 1'b1;
          hist      <= {hist[2:0], shreg[DATA_W-1]};
          shreg     <= shreg << 1;
          bit_cnt   <= bit_cnt + 1'b1;
        end
        S_STUFF: begin
          out       <= 1'b0;
          out_valid <= 1'b1;
          stuff     <= 1'b1;
          hist      <= {hist[2:0], 1'b0};
        end
        S_GAP: begin
          out       <= 1'b0;
          out_valid <= 1'b0;
          gap_cnt   <= gap_next;
          done      <= (gap_next == GW'(GAP));
        end
        default: begin
          out       <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq11011_tx.sv
// -----------------------------------------------------------------------------
// tb_seq11011_tx
//
// Two transmitters share clock and reset: unit 0 (GAP=2) takes directed
// frames, unit 1 (GAP=1) takes 1000 random frames. The stimulus pushes the
// expected frame for every accepted payload into a per-unit queue. A monitor
// per unit collects each frame off the line, destuffs it, runs an
// overlapping 11011 detector on it and compares against the queue head.
// -----------------------------------------------------------------------------
module tb_seq11011_tx;

  localparam int DW = 8;

  typedef struct packed {
    logic [63:0] bits;
    logic [63:0] stf;
    int          len;
    logic [7:0]  payload;
    logic        b2b;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start     [2];
  logic [7:0] data      [2];
  logic       ready     [2];
  logic       out       [2];
  logic       out_valid [2];
  logic       stuff     [2];
  logic       done      [2];

  int     checks   = 0;
  int     failures = 0;
  int     cyc      = 0;
  frame_t exp_q[2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame: sync word, then each payload bit MSB first; whenever
  // the last four bits on the line read 1101 after a payload bit, a 0 is
  // inserted and marked as stuffed.
  function automatic frame_t build(input logic [7:0] d, input logic b2b);
    frame_t     f;
    logic [4:0] sw;
    f  = '0;
    sw = 5'b11011;
    for (int i = 0; i < 5; i++) f.bits[i] = sw[4-i];
    f.len = 5;
    for (int i = 7; i >= 0; i--) begin
      f.bits[f.len] = d[i];
      f.len = f.len + 1;
      if (f.bits[f.len-4] && f.bits[f.len-3] && !f.bits[f.len-2] && f.bits[f.len-1]) begin
        f.stf[f.len] = 1'b1;
        f.len = f.len + 1;
      end
    end
    f.payload = d;
    f.b2b     = b2b;
    return f;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int G = (gi == 0) ? 2 : 1;

    seq11011_tx #(.DATA_W(DW), .GAP(G)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start[gi]),
      .data     (data[gi]),
      .ready    (ready[gi]),
      .out      (out[gi]),
      .out_valid(out_valid[gi]),
      .stuff    (stuff[gi]),
      .done     (done[gi])
    );

    logic        in_frame  = 1'b0;
    logic        ready_due = 1'b0;
    logic        bad_done;
    logic        bad_ready;
    int          len, fires, fire_pos, gap_n, first_cyc;
    int          last_done = -100;
    logic [4:0]  win = '0;
    logic [63:0] rb, rs;

    task automatic finish_frame();
      frame_t     e;
      logic [7:0] rec;
      int         rec_n;
      check("frame_expected", longint'(exp_q[gi].size() != 0), 1);
      if (exp_q[gi].size() != 0) begin
        e = exp_q[gi].pop_front();
        check("frame_len", len, e.len);
        check("frame_bits", rb, e.bits);
        check("stuff_mask", rs, e.stf);
        check("gap_len", gap_n, G);
        check("detector_fires", fires, 1);
        check("detector_pos", fire_pos, 4);
        check("done_ready_in_frame", {bad_done, bad_ready}, 0);
        // Destuff: after the sync word, drop every bit that follows 1101.
        rec   = '0;
        rec_n = 0;
        for (int i = 5; i < len && i < 64; i++) begin
          if (!(rb[i-4] && rb[i-3] && !rb[i-2] && rb[i-1])) begin
            rec   = {rec[6:0], rb[i]};
            rec_n = rec_n + 1;
          end
        end
        check("destuff_count", rec_n, DW);
        check("destuff_payload", rec, e.payload);
        if (e.b2b) check("b2b_spacing", first_cyc - last_done, 2);
      end
      last_done = cyc;
      in_frame  = 1'b0;
      ready_due = 1'b1;
    endtask

    always @(negedge clk) begin
      if (rst) begin
        in_frame  = 1'b0;
        ready_due = 1'b0;
        win       = '0;
      end else begin
        if (ready_due) begin
          check("ready_after_done", ready[gi], 1);
          ready_due = 1'b0;
        end
        win = {win[3:0], out[gi]};
        if (out_valid[gi]) begin
          if (!in_frame) begin
            in_frame  = 1'b1;
            len       = 0;
            fires     = 0;
            fire_pos  = -1;
            gap_n     = 0;
            rb        = '0;
            rs        = '0;
            bad_done  = 1'b0;
            bad_ready = 1'b0;
            first_cyc = cyc;
          end
          if (gap_n != 0) bad_done = 1'b1;
          if (len < 64) begin
            rb[len] = out[gi];
            rs[len] = stuff[gi];
          end
          if (win == 5'b11011) begin
            fires    = fires + 1;
            fire_pos = len;
          end
          len = len + 1;
          if (done[gi])  bad_done  = 1'b1;
          if (ready[gi]) bad_ready = 1'b1;
        end else begin
          check("idle_line", {out[gi], stuff[gi]}, 0);
          if (in_frame) begin
            gap_n = gap_n + 1;
            if (ready[gi]) bad_ready = 1'b1;
            if (done[gi]) finish_frame();
            else if (gap_n > G) begin
              check("done_timeout", gap_n, G);
              in_frame = 1'b0;
            end
          end else begin
            check("spurious_done", done[gi], 0);
          end
        end
      end
    end
  end

  task automatic send(input int u, input logic [7:0] d, input logic keep, input logic b2b);
    int n;
    @(negedge clk);
    start[u] = 1'b1;
    data[u]  = d;
    n = 0;
    while (!ready[u] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", ready[u], 1);
    if (ready[u]) exp_q[u].push_back(build(d, b2b));
    @(posedge clk);
    #1;
    if (!keep) start[u] = 1'b0;
    data[u] = 8'($urandom);
  endtask

  task automatic wait_idle(input int u);
    int n;
    n = 0;
    while ((exp_q[u].size() != 0 || !ready[u]) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q[u].size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic keep, prev_keep;
    rst   = 1'b1;
    start = '{1'b0, 1'b0};
    data  = '{8'h00, 8'h00};
    @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("reset_ready", ready[u], 1);
      check("reset_out", out[u], 0);
      check("reset_valid", out_valid[u], 0);
      check("reset_stuff", stuff[u], 0);
      check("reset_done", done[u], 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed frames on unit 0.
    send(0, 8'hA5, 1'b0, 1'b0);
    send(0, 8'hFF, 1'b0, 1'b0);
    send(0, 8'h6D, 1'b0, 1'b0);
    // Back-to-back with start held, then pulses while busy.
    send(0, 8'hA5, 1'b1, 1'b0);
    send(0, 8'hFF, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start[0] = 1'b1;
      data[0]  = 8'($urandom);
      @(negedge clk);
      start[0] = 1'b0;
    end
    wait_idle(0);

    // Reset and start together: reset wins.
    @(negedge clk);
    rst      = 1'b1;
    start[0] = 1'b1;
    data[0]  = 8'h3C;
    @(negedge clk);
    check("rst_start_ready", ready[0], 1);
    check("rst_start_valid", out_valid[0], 0);
    rst      = 1'b0;
    start[0] = 1'b0;

    // Reset during the third payload bit of A5.
    send(0, 8'hA5, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    check("abort_point_valid", out_valid[0], 1);
    check("abort_point_bit", out[0], 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_out", out[0], 0);
    check("abort_ready", ready[0], 1);
    check("abort_valid", out_valid[0], 0);
    check("abort_queue", exp_q[0].size(), 1);
    if (exp_q[0].size() != 0) void'(exp_q[0].pop_back());
    send(0, 8'hFF, 1'b0, 1'b0);
    wait_idle(0);

    // Random frames on unit 1.
    prev_keep = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      keep = (i < 999) && ($urandom_range(0, 3) == 0);
      send(1, 8'($urandom), keep, prev_keep);
      if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
      prev_keep = keep;
    end
    wait_idle(1);

    check("final_queue0", exp_q[0].size(), 0);
    check("final_queue1", exp_q[1].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
